// File: rtl/cell_editor_pkg.sv
// Shared board geometry and editor state types for the cell editor and its UI neighbours.
package cell_editor_pkg;

    localparam int LOG_BOARD_SIZE = 4;
    localparam int BOARD_SIZE     = 1 << LOG_BOARD_SIZE;

    typedef logic [2*LOG_BOARD_SIZE-1:0] cell_addr_t;

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        RWAIT,
        WRITE
    } editor_state_t;

endpackage

// File: rtl/cell_editor_rise_detect.sv
// Rising-edge detector for a level input; the history register resets "previously high"
// so a level held through reset produces no pulse.
module rise_detect (
    input  logic clk_in,
    input  logic rst_in,
    input  logic level_in,
    output logic pulse_out
);

    logic level_q;

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            level_q <= 1'b1;
        end else begin
            level_q <= level_in;
        end
    end

    assign pulse_out = level_in & ~level_q;

endmodule

// File: rtl/cell_editor.sv
// Read-modify-write engine that toggles the board cell under the cursor on each click.
// Optional paint-by-drag SET writes are enabled by defining CELL_EDITOR_DRAG_EN.
module cell_editor
    import cell_editor_pkg::*;
#(
    parameter int READ_LATENCY = 2
) (
    input  logic                        clk_in,
    input  logic                        rst_in,
    input  logic                        click_in,
    input  logic [LOG_BOARD_SIZE-1:0]   cursor_x_in,
    input  logic [LOG_BOARD_SIZE-1:0]   cursor_y_in,
    output logic                        mem_req_out,
    input  logic                        mem_gnt_in,
    output logic [2*LOG_BOARD_SIZE-1:0] mem_addr_out,
    output logic                        mem_we_out,
    output logic                        mem_wdata_out,
    input  logic                        mem_rdata_in,
    output logic                        busy_out,
    output logic                        done_out
);

    // Read data is valid in the last of READ_LATENCY cycles counted from the issue cycle,
    // so RWAIT lasts READ_LATENCY-1 cycles (none when the latency is 1).
    localparam logic [2:0] CNT_LOAD = 3'(READ_LATENCY - 1);

    editor_state_t state, state_next;
    cell_addr_t    cursor;
    cell_addr_t    addr;
    logic [2:0]    count;
    logic          rdata_q;
    logic          set_mode;
    logic          done;
    logic          click_edge;
    logic          start_set;
    logic          start;
    logic          capture;

    rise_detect u_click_edge (
        .clk_in    (clk_in),
        .rst_in    (rst_in),
        .level_in  (click_in),
        .pulse_out (click_edge)
    );

    assign cursor = {cursor_y_in, cursor_x_in};

`ifdef CELL_EDITOR_DRAG_EN
    cell_addr_t last_addr;

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            last_addr <= '0;
        end else if (state == IDLE && start) begin
            last_addr <= cursor;
        end
    end

    assign start_set = click_in & ~click_edge & (cursor != last_addr);
`else
    assign start_set = 1'b0;
`endif

    assign start   = click_edge | start_set;
    assign capture = (state == REQ && mem_gnt_in && !set_mode && READ_LATENCY == 1) ||
                     (state == RWAIT && count == 3'd1);

    // Control state
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            state    <= IDLE;
            count    <= '0;
            set_mode <= 1'b0;
            done     <= 1'b0;
        end else begin
            state <= state_next;
            done  <= (state == WRITE);
            if (state == IDLE && start) begin
                set_mode <= ~click_edge;
            end
            if (state == REQ && mem_gnt_in) begin
                count <= CNT_LOAD;
            end else if (state == RWAIT) begin
                count <= count - 3'd1;
            end
        end
    end

    // Datapath capture: address at start, read data in its valid cycle
    always_ff @(posedge clk_in) begin
        if (state == IDLE && start) begin
            addr <= cursor;
        end
        if (capture) begin
            rdata_q <= mem_rdata_in;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (start) state_next = REQ;
            end
            REQ: begin
                if (mem_gnt_in) begin
                    if (set_mode || READ_LATENCY == 1) state_next = WRITE;
                    else                               state_next = RWAIT;
                end
            end
            RWAIT: begin
                if (count == 3'd1) state_next = WRITE;
            end
            WRITE: begin
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    assign busy_out      = (state != IDLE);
    assign mem_req_out   = (state != IDLE);
    assign mem_we_out    = (state == WRITE);
    assign mem_wdata_out = (state == WRITE) ? (set_mode | ~rdata_q) : 1'b0;
    assign mem_addr_out  = (state == IDLE) ? '0 : addr;
    assign done_out      = done;

endmodule

// File: tb/tb_cell_editor.sv
// Directed bench for cell_editor: table of toggle transactions plus reset, busy-click and drag sequences.
module tb_cell_editor;

    logic       clk_in = 1'b0;
    logic       rst_in;
    logic       click_in;
    logic [3:0] cursor_x_in;
    logic [3:0] cursor_y_in;
    logic       mem_req_out;
    logic       mem_gnt_in;
    logic [7:0] mem_addr_out;
    logic       mem_we_out;
    logic       mem_wdata_out;
    logic       mem_rdata_in;
    logic       busy_out;
    logic       done_out;

    logic board [256];
    int   wr_count = 0;
    int   errors   = 0;
    int   checks   = 0;

    typedef struct {
        logic [3:0] x;
        logic [3:0] y;
        int         delay;
        logic       init;
        logic [7:0] addr;
        logic       wdata;
        int         wcyc;
    } vec_t;

    vec_t vecs[5];

    cell_editor #(.READ_LATENCY(2)) dut (
        .clk_in        (clk_in),
        .rst_in        (rst_in),
        .click_in      (click_in),
        .cursor_x_in   (cursor_x_in),
        .cursor_y_in   (cursor_y_in),
        .mem_req_out   (mem_req_out),
        .mem_gnt_in    (mem_gnt_in),
        .mem_addr_out  (mem_addr_out),
        .mem_we_out    (mem_we_out),
        .mem_wdata_out (mem_wdata_out),
        .mem_rdata_in  (mem_rdata_in),
        .busy_out      (busy_out),
        .done_out      (done_out)
    );

    always #5 clk_in = ~clk_in;

    assign mem_rdata_in = board[mem_addr_out];

    always @(posedge clk_in) begin
        if (mem_req_out && mem_gnt_in && mem_we_out) begin
            board[mem_addr_out] <= mem_wdata_out;
            wr_count <= wr_count + 1;
        end
    end

    task automatic step();
        @(posedge clk_in);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // One toggle transaction; cursor moves away after launch and grant is withheld v.delay cycles.
    task automatic run_vec(input vec_t v);
        int         wc;
        int         w0;
        logic [7:0] waddr;
        logic       wdata;
        logic       req_held;
        click_in   = 1'b0;
        mem_gnt_in = 1'b0;
        step();
        step();
        board[v.addr] = v.init;
        cursor_x_in   = v.x;
        cursor_y_in   = v.y;
        mem_gnt_in    = (v.delay == 0);
        click_in      = 1'b1;
        w0       = wr_count;
        wc       = 0;
        waddr    = '0;
        wdata    = 1'b0;
        req_held = 1'b1;
        for (int c = 1; c <= 40; c++) begin
            step();
            if (mem_we_out) begin
                wc    = c;
                waddr = mem_addr_out;
                wdata = mem_wdata_out;
                break;
            end
            if (!mem_req_out) req_held = 1'b0;
            if (c == 1) click_in = 1'b0;
            if (c == 2) cursor_x_in = 4'(v.x + 4'd1);
            if (c == 1 + v.delay) mem_gnt_in = 1'b1;
        end
        check("write_cycle", wc, v.wcyc);
        check("write_addr", waddr, v.addr);
        check("write_data", wdata, v.wdata);
        check("req_held", req_held, 1'b1);
        step();
        mem_gnt_in = 1'b0;
        check("done_pulse", {done_out, mem_req_out, busy_out}, 3'b100);
        step();
        check("done_clear", done_out, 1'b0);
        check("board_cell", board[v.addr], v.wdata);
        check("one_write", wr_count - w0, 1);
    endtask

    initial begin
        int   w0;
        logic bad;
        vecs[0] = '{4'd5,  4'd9,  0,  1'b0, 8'h95, 1'b1, 3};
        vecs[1] = '{4'd5,  4'd9,  10, 1'b0, 8'h95, 1'b1, 13};
        vecs[2] = '{4'd3,  4'd12, 0,  1'b1, 8'hC3, 1'b0, 3};
        vecs[3] = '{4'd15, 4'd15, 4,  1'b1, 8'hFF, 1'b0, 7};
        vecs[4] = '{4'd0,  4'd0,  2,  1'b0, 8'h00, 1'b1, 5};
        for (int i = 0; i < 256; i++) board[i] = 1'b0;

        // Button held through reset must not start anything
        rst_in      = 1'b1;
        click_in    = 1'b1;
        cursor_x_in = 4'd0;
        cursor_y_in = 4'd0;
        mem_gnt_in  = 1'b0;
        repeat (3) step();
        check("reset_outputs",
              {mem_req_out, mem_we_out, mem_wdata_out, mem_addr_out, busy_out, done_out}, '0);
        rst_in = 1'b0;
        bad = 1'b0;
        for (int c = 0; c < 20; c++) begin
            step();
            if (mem_req_out || busy_out) bad = 1'b1;
        end
        check("held_click_idle", bad, 1'b0);
        check("held_click_no_write", wr_count, 0);

        for (int i = 0; i < 5; i++) run_vec(vecs[i]);

        // Second click edge while in RWAIT is dropped
        click_in = 1'b0;
        step();
        step();
        board[8'hC3] = 1'b0;
        cursor_x_in  = 4'd3;
        cursor_y_in  = 4'd12;
        mem_gnt_in   = 1'b1;
        click_in     = 1'b1;
        w0 = wr_count;
        step();
        click_in = 1'b0;
        step();
        check("rwait_busy", busy_out, 1'b1);
        click_in = 1'b1;
        repeat (15) step();
        check("busy_click_one_write", wr_count - w0, 1);
        check("busy_click_cell", board[8'hC3], 1'b1);
        click_in   = 1'b0;
        mem_gnt_in = 1'b0;

        // Reset during RWAIT clears outputs at once, then a fresh click completes
        step();
        step();
        cursor_x_in = 4'd5;
        cursor_y_in = 4'd9;
        mem_gnt_in  = 1'b1;
        click_in    = 1'b1;
        w0 = wr_count;
        step();
        click_in = 1'b0;
        step();
        #1 rst_in = 1'b1;
        #1;
        check("async_reset_outputs",
              {mem_req_out, mem_we_out, mem_wdata_out, mem_addr_out, busy_out, done_out}, '0);
        step();
        rst_in = 1'b0;
        check("reset_no_write", wr_count - w0, 0);
        run_vec('{4'd5, 4'd9, 3, 1'b0, 8'h95, 1'b1, 6});

`ifdef CELL_EDITOR_DRAG_EN
        begin
            int         nw;
            int         wcyc [4];
            logic [7:0] wadr [4];
            logic       wdat [4];
            click_in   = 1'b0;
            mem_gnt_in = 1'b1;
            step();
            step();
            board[8'h95] = 1'b1;
            board[8'h96] = 1'b0;
            board[8'h97] = 1'b0;
            cursor_x_in  = 4'd5;
            cursor_y_in  = 4'd9;
            click_in     = 1'b1;
            nw = 0;
            for (int c = 1; c <= 32; c++) begin
                step();
                if (mem_we_out && nw < 4) begin
                    wcyc[nw] = c;
                    wadr[nw] = mem_addr_out;
                    wdat[nw] = mem_wdata_out;
                    nw++;
                end else if (mem_we_out) begin
                    nw++;
                end
                if (c == 8)  cursor_x_in = 4'd6;
                if (c == 16) cursor_x_in = 4'd7;
            end
            check("drag_write_count", nw, 3);
            if (nw >= 3) begin
                check("drag_toggle", {wcyc[0][7:0], wadr[0], 7'd0, wdat[0]}, {8'd3, 8'h95, 8'd0});
                check("drag_set_1",  {wcyc[1][7:0], wadr[1], 7'd0, wdat[1]}, {8'd10, 8'h96, 8'd1});
                check("drag_set_2",  {wcyc[2][7:0], wadr[2], 7'd0, wdat[2]}, {8'd18, 8'h97, 8'd1});
            end
            click_in   = 1'b0;
            mem_gnt_in = 1'b0;
        end
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d checks=%0d", errors, checks);
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/cell_editor.md
# cell_editor

Read-modify-write engine that applies the user's click to the game board. It consumes the debounced click level and cursor position produced by the user-interface block. On each click it acquires the board-memory port from the board arbiter, reads the cell under the cursor and writes back its complement. It sits between the user-interface block and the board-memory arbiter, alongside the evolution engine, which has arbiter priority.

## Interface
Parameters:
- READ_LATENCY, 2, cycles from a read issue (mem_req_out & mem_gnt_in & !mem_we_out) to valid mem_rdata_in; legal range 1..7.

Ports:
- clk_in  input  1  system clock; single clock domain
- rst_in  input  1  reset, asynchronous, active-high
- click_in  input  1  debounced click level (not a pulse)
- cursor_x_in  input  LOG_BOARD_SIZE  cursor column
- cursor_y_in  input  LOG_BOARD_SIZE  cursor row
- mem_req_out  output  1  board-port request; held for the whole transaction
- mem_gnt_in  input  1  arbiter grant; once asserted, stays high until mem_req_out drops
- mem_addr_out  output  2*LOG_BOARD_SIZE  cell address {y, x}
- mem_we_out  output  1  write enable
- mem_wdata_out  output  1  write data
- mem_rdata_in  input  1  read data
- busy_out  output  1  high whenever state != IDLE
- done_out  output  1  one-cycle pulse when a transaction completes

## Operation
- States and transitions:
  - IDLE: on a start event, latch {cursor_y_in, cursor_x_in} into the address register → REQ.
  - REQ: mem_req_out=1, mem_we_out=0. On the first cycle with mem_gnt_in=1, that cycle is the read issue; load the latency counter → RWAIT.
  - RWAIT: count READ_LATENCY cycles. In the cycle mem_rdata_in is valid → WRITE.
  - WRITE: mem_we_out=1, mem_wdata_out = ~rdata registered from RWAIT. Next cycle → IDLE with done_out=1.
- Start event: rising edge of click_in, i.e. click_in=1 while the previous-sample register click_q=0.
- Clicks while busy_out=1 are dropped; no queueing.
- The latched address is stable for the whole transaction; cursor motion during a transaction has no effect.
- mem_addr_out always drives the latched address; it is 0 in IDLE.

## Timing
- Reset values: mem_req_out=0, mem_we_out=0, mem_wdata_out=0, mem_addr_out=0, busy_out=0, done_out=0, state=IDLE.
- click_q resets to 1, so a button held through reset does not toggle a cell.
- Edge seen at cycle 0 → mem_req_out=1 at cycle 1.
- Grant at cycle g → write at cycle g+READ_LATENCY → mem_req_out=0 and done_out=1 at cycle g+READ_LATENCY+1.
- Minimum transaction with immediate grant: READ_LATENCY+2 cycles from the edge to done_out.
- Reset asserted mid-transaction: all outputs go to their reset values immediately. A write already issued may or may not have landed; no partial-write retry is attempted.
- If mem_gnt_in is low in REQ, wait indefinitely. No timeout.
- Address arithmetic: the address is a straight concatenation; board wrap-around is handled by the cursor source, not here.

## Configuration
- CELL_EDITOR_DRAG_EN defined:
  - Paint-by-drag is enabled.
  - In IDLE, when click_in=1, there is no rising edge, and {cursor_y_in, cursor_x_in} differs from the last-edited address, start a SET transaction.
  - A SET transaction goes REQ → WRITE directly on grant, with mem_wdata_out=1 and no read. done_out pulses as usual.
  - The rising edge still performs a toggle; the last-edited address register updates on every transaction.
- CELL_EDITOR_DRAG_EN undefined: only rising edges start transactions, and the last-edited address register is not built.

## Structure
- Shared package (common.svh) holds:
  - LOG_BOARD_SIZE and BOARD_SIZE
  - new typedef cell_addr_t (logic[2*LOG_BOARD_SIZE-1:0])
  - editor_state_t enum {IDLE, REQ, RWAIT, WRITE}
- One sub-module: rise_detect (clk_in, rst_in, level_in, pulse_out, with reset state "previously high"), reusable by other UI consumers.
- Everything else stays in cell_editor.

## Test plan
- Reset release with click_in held at 1 → no mem_req_out for 20 cycles, and busy_out=0.
- Cursor (5,9), click edge, mem_gnt_in tied high, READ_LATENCY=2, memory returns 0:
  - read at cycle 1 with addr {9,5}
  - write of 1 at cycle 3
  - done_out at cycle 4
- Same toggle with mem_gnt_in withheld 10 cycles → mem_req_out stays high throughout; the write is delayed exactly 10 cycles; the cursor moved to (6,9) mid-wait still writes {9,5}.
- Second click edge during RWAIT → ignored; exactly one write occurs.
- rst_in pulsed in RWAIT → all outputs 0 in the same cycle; the next click edge completes normally.
- With CELL_EDITOR_DRAG_EN: hold click and step the cursor (5,9)→(6,9)→(7,9):
  - one toggle at (5,9)
  - SET writes of 1 at (6,9) and (7,9), no reads issued
  - no repeat write while the cursor is stationary
